// File: rtl/cache_mem_pkg.sv
// Shared types and line geometry for the data-cache main-memory responder.
// Default widths match the WB-stage data cache configuration.
package cache_mem_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam int unsigned LINE_ADDR_LEN_DEF = 3;
    localparam int unsigned MEM_ADDR_LEN_DEF  = 9;
    localparam int unsigned LATENCY_DEF       = 8;

    localparam int unsigned LINE_WORDS = 2 ** LINE_ADDR_LEN_DEF;
    localparam int unsigned LINE_BITS  = 32 * LINE_WORDS;

    // Word i of a line sits at bits [32i+31:32i].
    function automatic logic [31:0] line_word(input logic [LINE_BITS-1:0] line,
                                              input int unsigned i);
        return line[32*i +: 32];
    endfunction

endpackage

// File: rtl/mem_line_array.sv
// Word-organised backing store with one line-wide port and one word-wide debug port.
// A line write beats a debug write to the same line in the same cycle.
module mem_line_array #(
    parameter int unsigned LINE_ADDR_LEN = 3,
    parameter int unsigned MEM_ADDR_LEN  = 9
) (
    input  logic                                  clk,
    input  logic [MEM_ADDR_LEN-1:0]               line_addr,
    input  logic                                  line_we,
    input  logic [32*(2**LINE_ADDR_LEN)-1:0]      line_wdata,
    output logic [32*(2**LINE_ADDR_LEN)-1:0]      line_rdata,
    input  logic [MEM_ADDR_LEN+LINE_ADDR_LEN-1:0] debug_addr,
    input  logic                                  debug_we,
    input  logic [31:0]                           debug_wdata,
    output logic [31:0]                           debug_rdata
);
    localparam int unsigned LW    = 2 ** LINE_ADDR_LEN;
    localparam int unsigned DEPTH = 2 ** (MEM_ADDR_LEN + LINE_ADDR_LEN);

    logic [31:0] mem [DEPTH];
    logic        debug_hit;

    // A line write replaces every word of its line, so dropping any debug write to
    // that line gives the same result as dropping only the colliding word.
    assign debug_hit = line_we &&
        (debug_addr[MEM_ADDR_LEN+LINE_ADDR_LEN-1:LINE_ADDR_LEN] == line_addr);

    always_comb begin
        line_rdata = '0;
        for (int i = 0; i < LW; i++) begin
            line_rdata[32*i +: 32] = mem[{line_addr, LINE_ADDR_LEN'(i)}];
        end
    end

    assign debug_rdata = mem[debug_addr];

    always_ff @(posedge clk) begin
        if (debug_we && !debug_hit) begin
            mem[debug_addr] <= debug_wdata;
        end
        if (line_we) begin
            for (int i = 0; i < LW; i++) begin
                mem[{line_addr, LINE_ADDR_LEN'(i)}] <= line_wdata[32*i +: 32];
            end
        end
    end

endmodule

// File: rtl/mem_line_responder.sv
// Fixed-latency main-memory responder for data-cache line refills and write-backs.
// Completion is signalled by a one-cycle grant; a debug word port inspects and patches memory.
module mem_line_responder
    import cache_mem_pkg::*;
#(
    parameter int unsigned LINE_ADDR_LEN = LINE_ADDR_LEN_DEF,
    parameter int unsigned MEM_ADDR_LEN  = MEM_ADDR_LEN_DEF,
    parameter int unsigned LATENCY       = LATENCY_DEF
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  mem_rd_req,
    input  logic                                  mem_wr_req,
    input  logic [MEM_ADDR_LEN-1:0]               mem_addr,
    input  logic [32*(2**LINE_ADDR_LEN)-1:0]      mem_wr_line,
    output logic [32*(2**LINE_ADDR_LEN)-1:0]      mem_rd_line,
    output logic                                  mem_gnt,
    input  logic [MEM_ADDR_LEN+LINE_ADDR_LEN-1:0] debug_addr,
    input  logic                                  debug_wr_en,
    input  logic [31:0]                           debug_in_data,
    output logic [31:0]                           debug_out_data,
    output logic [31:0]                           rd_count,
    output logic [31:0]                           wr_count
);
    localparam int unsigned LB    = 32 * (2 ** LINE_ADDR_LEN);
    localparam int unsigned CNT_W = $clog2(LATENCY);

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    op_wr_q;
    logic [MEM_ADDR_LEN-1:0] addr_q;
    logic [LB-1:0]           wdata_q;
    logic [LB-1:0]           rd_line_q;
    logic                    gnt_q;
    logic [31:0]             rd_count_q;
    logic [31:0]             wr_count_q;

    logic                    finish;
    logic                    line_we;
    logic [LB-1:0]           array_line;

    assign finish  = (state_q == BUSY) && (cnt_q == '0);
    // Gated by rst so a transaction abandoned at its final edge leaves memory untouched.
    assign line_we = finish && op_wr_q && !rst;

    mem_line_array #(
        .LINE_ADDR_LEN (LINE_ADDR_LEN),
        .MEM_ADDR_LEN  (MEM_ADDR_LEN)
    ) u_array (
        .clk         (clk),
        .line_addr   (addr_q),
        .line_we     (line_we),
        .line_wdata  (wdata_q),
        .line_rdata  (array_line),
        .debug_addr  (debug_addr),
        .debug_we    (debug_wr_en),
        .debug_wdata (debug_in_data),
        .debug_rdata (debug_out_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_wr_q    <= 1'b0;
            rd_line_q  <= '0;
            gnt_q      <= 1'b0;
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            gnt_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // Write-back is taken ahead of a simultaneous refill.
                    if (mem_wr_req || mem_rd_req) begin
                        op_wr_q <= mem_wr_req;
                        addr_q  <= mem_addr;
                        wdata_q <= mem_wr_line;
                        cnt_q   <= CNT_W'(LATENCY - 2);
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q == '0) begin
                        if (op_wr_q) begin
                            wr_count_q <= wr_count_q + 32'd1;
                        end else begin
                            rd_line_q  <= array_line;
                            rd_count_q <= rd_count_q + 32'd1;
                        end
                        gnt_q   <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_rd_line = rd_line_q;
    assign mem_gnt     = gnt_q;
    assign rd_count    = rd_count_q;
    assign wr_count    = wr_count_q;

endmodule
